multisim_push_arbiter: RTL and testbench



---
 rtl/multisim_push_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_multisim_push_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multisim_push_arbiter.sv
// -----------------------------------------------------------------------------
// multisim_push_arbiter
//
// Round-robin arbiter that shares one multisim push client among NUM_REQ
// local requesters. One requester holds the grant at a time, for at most
// MAX_BURST consecutive beats, and its beats are forwarded through a
// single-entry output register that drives the push client.
//
// Optional feature (compile-time macro): MULTISIM_PUSH_ARB_TAG_EN
//   defined   : out_data = {granted index, payload}, OUT_WIDTH = DATA_WIDTH+IDX_W
//   undefined : out_data = payload,                  OUT_WIDTH = DATA_WIDTH
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   in_vld     in   [NUM_REQ]            per-requester valid
//   in_rdy     out  [NUM_REQ]            per-requester ready
//   in_data    in   [NUM_REQ*DATA_WIDTH] requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_vld    out  to push client data_vld
//   out_rdy    in   from push client data_rdy
//   out_data   out  [OUT_WIDTH] to push client data
//   grant_vld  out  FSM state: 1 = GRANT, 0 = IDLE
//   grant_idx  out  [IDX_W] index of the granted requester
//
// Handshake: a beat moves across an interface on a rising edge where both
// vld and rdy are high. A source keeps vld and data stable until that edge;
// rdy may depend combinationally on the sink's state, vld never on rdy.
// -----------------------------------------------------------------------------
module multisim_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 8,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
`ifdef MULTISIM_PUSH_ARB_TAG_EN
  localparam int OUT_WIDTH = DATA_WIDTH + IDX_W
`else
  localparam int OUT_WIDTH = DATA_WIDTH
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            in_vld,
  output logic [NUM_REQ-1:0]            in_rdy,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          grant_vld,
  output logic [IDX_W-1:0]              grant_idx
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [8:0] MAX_BURST_9 = 9'(MAX_BURST);

  state_t                 state;
  logic [IDX_W-1:0]       gidx_q;
  logic [IDX_W-1:0]       last_idx_q;
  logic [7:0]             burst_cnt_q;
  logic                   out_vld_q;
  logic [OUT_WIDTH-1:0]   out_data_q;

  logic                   grant_on;
  logic                   out_free;
  logic [NUM_REQ-1:0]     grant_oh;
  logic [DATA_WIDTH-1:0]  cur_data;
  logic [OUT_WIDTH-1:0]   out_word;
  logic                   cur_vld;
  logic                   xfer;
  logic                   burst_last;
  logic                   exhausted;
  logic                   release_g;
  logic [IDX_W-1:0]       scan_base;
  logic [NUM_REQ-1:0]     scan_mask;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;

  assign grant_on = (state == GRANT);
  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = !out_vld_q || out_rdy;

  // One-hot of the granted index and its payload, built with constant selects.
  always_comb begin
    grant_oh = '0;
    cur_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        grant_oh[i] = 1'b1;
        cur_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef MULTISIM_PUSH_ARB_TAG_EN
  assign out_word = {gidx_q, cur_data};
`else
  assign out_word = cur_data;
`endif

  assign cur_vld    = |(in_vld & grant_oh);
  assign xfer       = grant_on && cur_vld && out_free;
  assign burst_last = (({1'b0, burst_cnt_q} + 9'd1) == MAX_BURST_9);
  assign exhausted  = xfer && burst_last;
  assign release_g  = grant_on && (!cur_vld || exhausted);

  assign in_rdy = (grant_on && out_free) ? grant_oh : '0;

  // Scan origin is the previous owner: last_idx when idle, the current grant
  // when re-arbitrating on release (which becomes last_idx on the same edge).
  // An exhausted requester steps aside so others get a turn; with a single
  // requester there is nobody to yield to, so it is re-granted without a gap.
  assign scan_base = grant_on ? gidx_q : last_idx_q;
  assign scan_mask = in_vld & ~((exhausted && (NUM_REQ > 1)) ? grant_oh : '0);

  // Walk from farthest to nearest so the last hit is the first set bit after
  // scan_base with wrap-around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(scan_base) + k) % NUM_REQ);
      if (scan_mask[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gidx_q      <= '0;
      last_idx_q  <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // Output register: fill wins over drain; held while out_rdy is low.
      if (xfer) begin
        out_vld_q  <= 1'b1;
        out_data_q <= out_word;
      end else if (out_rdy) begin
        out_vld_q  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            state  <= GRANT;
            gidx_q <= pick_idx;
          end
        end
        GRANT: begin
          if (release_g) begin
            last_idx_q  <= gidx_q;
            burst_cnt_q <= '0;
            if (pick_found) begin
              gidx_q <= pick_idx;
            end else begin
              state  <= IDLE;
            end
          end else if (xfer) begin
            burst_cnt_q <= burst_cnt_q + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_vld   = out_vld_q;
  assign out_data  = out_data_q;
  assign grant_vld = grant_on;
  assign grant_idx = gidx_q;

endmodule

// File: tb/tb_multisim_push_arbiter.sv
// -----------------------------------------------------------------------------
// tb_multisim_push_arbiter
//
// Bench for multisim_push_arbiter with NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=2.
// A reference model tracks the owner, the round-robin pointer, the beats used
// in the current burst and the expected output beat queue, and is compared to
// the DUT every cycle; directed scenarios add explicit constant expectations.
// Works with or without MULTISIM_PUSH_ARB_TAG_EN defined.
// -----------------------------------------------------------------------------
module tb_multisim_push_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 2;
  localparam int IW = 2;
`ifdef MULTISIM_PUSH_ARB_TAG_EN
  localparam int OW = DW + IW;
  localparam logic [OW-1:0] T6_EXP = 10'h35A;
`else
  localparam int OW = DW;
  localparam logic [OW-1:0] T6_EXP = 8'h5A;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    in_vld;
  logic [NR-1:0]    in_rdy;
  logic [NR*DW-1:0] in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [OW-1:0]    out_data;
  logic             grant_vld;
  logic [IW-1:0]    grant_idx;
  logic [DW-1:0]    slot [NR];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NR; i++) begin : g_pack
    assign in_data[i*DW +: DW] = slot[i];
  end

  multisim_push_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .grant_vld(grant_vld),
    .grant_idx(grant_idx)
  );

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_owner;     // -1 when nobody holds the grant
  int            m_last;
  int            m_beats;
  logic [OW-1:0] exp_q [$];   // beat waiting in the output register

  // Observations from the last cycle, used by the drivers.
  logic [NR-1:0] xfer_seen;
  logic          out_fire;
  logic [OW-1:0] out_seen;

`ifdef MULTISIM_PUSH_ARB_TAG_EN
  function automatic logic [OW-1:0] word(input int idx, input logic [DW-1:0] d);
    return {IW'(idx), d};
  endfunction
`else
  function automatic logic [OW-1:0] word(input int idx, input logic [DW-1:0] d);
    word = d;
    if (idx < 0) word = '0;
  endfunction
`endif

  // First requester set in mask after position 'after', wrapping; -1 if none.
  function automatic int rr_pick(input logic [NR-1:0] mask, input int after);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (after + k) % NR;
      if (mask[IW'(idx)]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = NR - 1;
    m_beats = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int            g;
    logic          x;
    logic [NR-1:0] mask;
    if (rst) begin
      model_reset();
      return;
    end
    g = m_owner;
    x = (g >= 0) && in_vld[IW'(g)] && (exp_q.size() == 0 || out_rdy);
    if (exp_q.size() != 0 && out_rdy) void'(exp_q.pop_front());
    if (x) exp_q.push_back(word(g, slot[IW'(g)]));
    if (g < 0) begin
      if (in_vld != '0) m_owner = rr_pick(in_vld, m_last);
    end else begin
      if (x) m_beats++;
      if (!in_vld[IW'(g)] || (x && m_beats == MB)) begin
        mask = in_vld;
        if (x && m_beats == MB) mask[IW'(g)] = 1'b0;
        m_last  = g;
        m_beats = 0;
        m_owner = rr_pick(mask, g);
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model, return #1
  // after the next rising edge so the caller can drive new inputs.
  task automatic cycle();
    logic [NR-1:0] er;
    @(negedge clk);
    er = '0;
    if (m_owner >= 0 && (exp_q.size() == 0 || out_rdy)) er[IW'(m_owner)] = 1'b1;
    check("grant_vld", 64'(grant_vld), 64'(m_owner >= 0));
    if (m_owner >= 0) check("grant_idx", 64'(grant_idx), 64'(m_owner));
    check("in_rdy", 64'(in_rdy), 64'(er));
    check("out_vld", 64'(out_vld), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("out_data", 64'(out_data), 64'(exp_q[0]));
    xfer_seen = in_vld & in_rdy;
    out_fire  = out_vld & out_rdy;
    out_seen  = out_data;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int k;
    int n;
    int stall;
    bit stall_done;
    bit started;
    bit found;
    int seq [NR];

    rst     = 1'b1;
    in_vld  = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < NR; i++) begin
      slot[i] = 8'hC0 + 8'(i);
      seq[i]  = 0;
    end
    model_reset();
    @(posedge clk);
    #1;

    // T1: reset with all requesters valid; requester 0 wins first.
    in_vld = 4'b1111;
    do_reset();
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_grant_vld", 64'(grant_vld), 64'd0);
    check("rst_grant_idx", 64'(grant_idx), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_in_rdy", 64'(in_rdy), 64'd0);
    cycle();
    check("t1_grant_vld", 64'(grant_vld), 64'd1);
    check("t1_grant_idx", 64'(grant_idx), 64'd0);
    check("t1_in_rdy", 64'(in_rdy), 64'b0001);
    cycle();
    check("t1_out_vld", 64'(out_vld), 64'd1);
    check("t1_out_data", 64'(out_data), 64'(word(0, 8'hC0)));

    // T2: all valid, out_rdy=1 -> sources 0,0,1,1,2,2,3,3,0,0,1,1 back to back.
    for (int i = 0; i < NR; i++) slot[i] = 8'((i << 4));
    in_vld = 4'b1111;
    do_reset();
    k = 0;
    started = 1'b0;
    for (int c = 0; c < 40 && k < 12; c++) begin
      cycle();
      if (out_fire) started = 1'b1;
      if (started) begin
        check("t2_no_bubble", 64'(out_fire), 64'd1);
        check("t2_src", 64'(out_seen[7:4]), 64'((k / 2) % NR));
        k++;
      end
      for (int i = 0; i < NR; i++) begin
        if (xfer_seen[IW'(i)]) begin
          seq[i]++;
          slot[IW'(i)] = 8'((i << 4) | (seq[i] & 15));
        end
      end
    end
    check("t2_beats", 64'(k), 64'd12);

    // T3: requester 2 alone sends 0xA..0xE; sink stalls 3 cycles on 0xB.
    in_vld = '0;
    do_reset();
    k = 0;
    n = 0;
    stall = 0;
    stall_done = 1'b0;
    in_vld = 4'b0100;
    slot[2] = 8'h0A;
    out_rdy = 1'b1;
    for (int c = 0; c < 60 && n < 5; c++) begin
      cycle();
      if (out_fire) begin
        check("t3_order", 64'(out_seen), 64'(word(2, 8'h0A + 8'(n))));
        n++;
      end
      if (xfer_seen[2]) k++;
      in_vld  = (k < 5) ? 4'b0100 : 4'b0000;
      slot[2] = 8'h0A + 8'(k);
      if (stall > 0) stall--;
      if (!stall_done && out_vld && out_data == word(2, 8'h0B)) begin
        stall = 3;
        stall_done = 1'b1;
      end
      out_rdy = (stall == 0);
      #1;
      if (stall > 0) begin
        check("t3_hold_data", 64'(out_data), 64'(word(2, 8'h0B)));
        check("t3_hold_vld", 64'(out_vld), 64'd1);
        check("t3_in_rdy2", 64'(in_rdy[2]), 64'd0);
      end
    end
    check("t3_count", 64'(n), 64'd5);
    check("t3_stalled", 64'(stall_done), 64'd1);
    out_rdy = 1'b1;

    // T4: requester 1 drops after one beat -> grant moves to 3 on the same
    // edge; requester 0 waits until 3 exhausts its burst.
    in_vld = '0;
    do_reset();
    slot[0] = 8'h00;
    slot[1] = 8'h11;
    slot[3] = 8'h33;
    in_vld = 4'b1010;
    cycle();
    check("t4_first", 64'(grant_idx), 64'd1);
    cycle();
    check("t4_hold1", 64'(grant_idx), 64'd1);
    in_vld = 4'b1000;
    cycle();
    check("t4_move_vld", 64'(grant_vld), 64'd1);
    check("t4_move_idx", 64'(grant_idx), 64'd3);
    in_vld = 4'b1001;
    cycle();
    check("t4_r0_waits", 64'(grant_idx), 64'd3);
    cycle();
    check("t4_r0_turn", 64'(grant_idx), 64'd0);
    in_vld = 4'b0000;
    cycle();
    cycle();

    // T5: reset while a beat is held and requester 3 is granted.
    do_reset();
    in_vld = 4'b1000;
    out_rdy = 1'b0;
    cycle();
    cycle();
    check("t5_pre_idx", 64'(grant_idx), 64'd3);
    check("t5_pre_vld", 64'(out_vld), 64'd1);
    rst = 1'b1;
    in_vld = 4'b1110;
    cycle();
    check("t5_out_vld", 64'(out_vld), 64'd0);
    check("t5_grant_vld", 64'(grant_vld), 64'd0);
    rst = 1'b0;
    out_rdy = 1'b1;
    cycle();
    check("t5_regrant_vld", 64'(grant_vld), 64'd1);
    check("t5_regrant_idx", 64'(grant_idx), 64'd1);

    // T6: tag format, requester 3 sends 0x5A.
    in_vld = '0;
    do_reset();
    slot[3] = 8'h5A;
    in_vld = 4'b1000;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cycle();
      if (xfer_seen[3]) in_vld[3] = 1'b0;
      if (out_vld) found = 1'b1;
    end
    check("t6_seen", 64'(found), 64'd1);
    check("t6_tag", 64'(out_data), 64'(T6_EXP));
    cycle();

    // Random phase: protocol-legal valids, random backpressure, rare resets.
    in_vld = '0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      cycle();
      for (int i = 0; i < NR; i++) begin
        if (!(in_vld[IW'(i)] && !xfer_seen[IW'(i)])) begin
          in_vld[IW'(i)] = ($urandom_range(0, 99) < 60);
          slot[IW'(i)]   = 8'($urandom);
        end
      end
      out_rdy = ($urandom_range(0, 99) < 70);
      rst     = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
